fetch_queue: RTL and testbench

//  Instruction fetch queue, directly upstream of Decoder. Buffers 128-bit

---
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue: buffers fetch packets and issues one instruction per cycle
module fetch_queue #(
    parameter int XPR_LEN       = 32,
    parameter int CHANNEL_DEPTH = 4,
    parameter int QUEUE_PACKETS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fetch_valid,
    output logic                               fetch_ready,
    input  logic [CHANNEL_DEPTH*XPR_LEN-1:0]   fetch_data,
    input  logic [XPR_LEN-1:0]                 fetch_pc,
    input  logic [$clog2(CHANNEL_DEPTH)-1:0]   fetch_offset,
    output logic                               inst_valid,
    input  logic                               inst_ready,
    output logic [XPR_LEN-1:0]                 inst,
    output logic [XPR_LEN-1:0]                 inst_pc,
    input  logic                               drop
);

    localparam int OFF_W = $clog2(CHANNEL_DEPTH);
    localparam int PTR_W = $clog2(QUEUE_PACKETS);
    localparam int CNT_W = $clog2(QUEUE_PACKETS + 1);
    localparam int LSB   = OFF_W + 2;
    localparam int PKT_W = CHANNEL_DEPTH * XPR_LEN;
    localparam logic [XPR_LEN-1:0] PC_MASK = ~((XPR_LEN'(1) << LSB) - XPR_LEN'(1));

    logic [PKT_W-1:0]   data_q [QUEUE_PACKETS];
    logic [PKT_W-1:0]   data_d [QUEUE_PACKETS];
    logic [XPR_LEN-1:0] pc_q   [QUEUE_PACKETS];
    logic [XPR_LEN-1:0] pc_d   [QUEUE_PACKETS];
    logic [OFF_W-1:0]   idx_q  [QUEUE_PACKETS];
    logic [OFF_W-1:0]   idx_d  [QUEUE_PACKETS];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [OFF_W-1:0]   head_idx;
    logic               push;
    logic               pop;
    logic               retire;

    assign fetch_ready = (count_q != CNT_W'(QUEUE_PACKETS)) && !drop;
    assign inst_valid  = (count_q != '0);

    assign head_idx = idx_q[rd_ptr_q];
    assign inst     = data_q[rd_ptr_q][head_idx*XPR_LEN +: XPR_LEN];
    // Packet base is aligned here so the stored PC can keep the raw request address.
    assign inst_pc  = (pc_q[rd_ptr_q] & PC_MASK) + (XPR_LEN'(head_idx) << 2);

    // A pop concurrent with drop is discarded, so it must not move any state.
    assign push   = fetch_valid && fetch_ready;
    assign pop    = inst_valid && inst_ready && !drop;
    assign retire = pop && (head_idx == OFF_W'(CHANNEL_DEPTH - 1));

    always_comb begin
        data_d   = data_q;
        pc_d     = pc_q;
        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            data_d[wr_ptr_q] = fetch_data;
            pc_d[wr_ptr_q]   = fetch_pc;
            idx_d[wr_ptr_q]  = fetch_offset;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        // push targets the head slot only when empty, where no pop can happen
        if (pop && !retire)
            idx_d[rd_ptr_q] = head_idx + OFF_W'(1);
        if (retire)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (push && !retire)
            count_d = count_q + CNT_W'(1);
        else if (!push && retire)
            count_d = count_q - CNT_W'(1);

        if (drop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_PACKETS; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
                idx_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized self-checking bench for fetch_queue
module tb_fetch_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [127:0] fetch_data;
    logic [31:0]  fetch_pc;
    logic [1:0]   fetch_offset;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_inst [$];
    logic [31:0] exp_pc   [$];

    fetch_queue #(
        .XPR_LEN(32), .CHANNEL_DEPTH(4), .QUEUE_PACKETS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch_pc(fetch_pc), .fetch_offset(fetch_offset),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [31:0] pc, input logic [31:0] w0, input logic [1:0] off);
        fetch_valid  = 1'b1;
        fetch_pc     = pc;
        fetch_offset = off;
        fetch_data   = {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
    endtask

    initial begin
        logic [31:0] s_pc;
        logic [31:0] s_w [4];
        logic [1:0]  s_off;
        int          sent;
        int          cyc;

        rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0;
        fetch_offset = '0; inst_ready = 1'b0; drop = 1'b0;
        #2;
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // single packet streamed back to back
        set_pkt(32'h1000, 32'hA0, 2'd0);
        inst_ready = 1'b1;
        tick();
        fetch_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", 32'(inst_valid), 32'd1);
            check("t2_inst", inst, 32'hA0 + 32'(i));
            check("t2_pc", inst_pc, 32'h1000 + 32'(4 * i));
            tick();
        end
        check("t2_empty", 32'(inst_valid), 32'd0);

        // asynchronous reset in the middle of a packet
        set_pkt(32'h7000, 32'h70, 2'd0);
        tick();
        fetch_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t1_inst_valid", 32'(inst_valid), 32'd0);
        check("t1_fetch_ready", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t1_no_inst", 32'(inst_valid), 32'd0);

        // fill to full, then drain word by word
        inst_ready = 1'b0;
        set_pkt(32'h3000, 32'hC0, 2'd0);
        tick();
        set_pkt(32'h3010, 32'hD0, 2'd0);
        tick();
        fetch_valid = 1'b0;
        check("t3_full", 32'(fetch_ready), 32'd0);
        for (int p = 0; p < 3; p++) begin
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
            check("t3_still_full", 32'(fetch_ready), 32'd0);
            check("t3_inst", inst, 32'hC1 + 32'(p));
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t3_slot_free", 32'(fetch_ready), 32'd1);
        check("t3_next_inst", inst, 32'hD0);
        check("t3_next_pc", inst_pc, 32'h3010);
        inst_ready = 1'b1;
        repeat (4) tick();
        check("t3_drained", 32'(inst_valid), 32'd0);

        // mid-packet start with unaligned base address
        set_pkt(32'h2014, 32'hB0, 2'd2);
        tick();
        fetch_valid = 1'b0;
        check("t4_inst0", inst, 32'hB2);
        check("t4_pc0", inst_pc, 32'h2018);
        tick();
        check("t4_inst1", inst, 32'hB3);
        check("t4_pc1", inst_pc, 32'h201C);
        tick();
        check("t4_empty", 32'(inst_valid), 32'd0);

        // flush with 1.5 packets queued and a packet offered in the same cycle
        inst_ready = 1'b0;
        set_pkt(32'h4000, 32'hE0, 2'd0);
        tick();
        set_pkt(32'h5000, 32'hF0, 2'd0);
        tick();
        fetch_valid = 1'b0;
        inst_ready  = 1'b1;
        tick();
        tick();
        drop = 1'b1;
        set_pkt(32'h6000, 32'h60, 2'd0);
        #1;
        check("t5_ready_in_drop", 32'(fetch_ready), 32'd0);
        check("t5_head_before", inst, 32'hE2);
        tick();
        drop = 1'b0; fetch_valid = 1'b0; inst_ready = 1'b0;
        #1;
        check("t5_valid_after", 32'(inst_valid), 32'd0);
        check("t5_ready_after", 32'(fetch_ready), 32'd1);
        tick();
        tick();
        check("t5_no_ghost", 32'(inst_valid), 32'd0);
        set_pkt(32'h8000, 32'h80, 2'd1);
        tick();
        fetch_valid = 1'b0;
        check("t5_new_inst", inst, 32'h81);
        check("t5_new_pc", inst_pc, 32'h8004);
        inst_ready = 1'b1;
        repeat (3) tick();
        check("t5_new_drained", 32'(inst_valid), 32'd0);

        // random traffic against an in-order word model
        sent = 0;
        cyc  = 0;
        s_pc  = $urandom;
        s_off = 2'($urandom_range(0, 3));
        for (int w = 0; w < 4; w++) s_w[w] = $urandom;
        while ((sent < 20 || exp_inst.size() != 0) && cyc < 3000) begin
            fetch_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            fetch_pc     = s_pc;
            fetch_offset = s_off;
            fetch_data   = {s_w[3], s_w[2], s_w[1], s_w[0]};
            inst_ready   = ($urandom_range(0, 2) != 0);
            #1;
            if (fetch_valid && fetch_ready) begin
                for (int w = int'(s_off); w < 4; w++) begin
                    exp_inst.push_back(s_w[w]);
                    exp_pc.push_back({s_pc[31:4], 4'h0} + 32'(4 * w));
                end
                sent++;
                s_pc  = $urandom;
                s_off = 2'($urandom_range(0, 3));
                for (int w = 0; w < 4; w++) s_w[w] = $urandom;
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) begin
                    check("t6_spurious_inst", 32'(inst_valid), 32'd0);
                end else begin
                    check("t6_inst", inst, exp_inst.pop_front());
                    check("t6_pc", inst_pc, exp_pc.pop_front());
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        fetch_valid = 1'b0;
        inst_ready  = 1'b0;
        check("t6_timeout", 32'(cyc < 3000), 32'd1);
        check("t6_final_empty", 32'(inst_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
